// File: rtl/hex_sched_pkg.sv
// Shared types and constants for the HEX display scheduler.
// Blanking between sources is enabled with the HEX_SCHED_BLANK_EN macro.
package hex_sched_pkg;

    typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam int         NUM_SRC   = 4;

    function automatic logic [NUM_SRC-1:0] sel_onehot(input logic [1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/hex_display_scheduler_seg7.sv
// Hex nibble to 7-segment decoder, active-low, bit 6 = g ... bit 0 = a.
module hex_display_scheduler_seg7 (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// Rotates four 8-bit debug sources onto two HEX digits with dwell timer, step key and hold.
// Define HEX_SCHED_BLANK_EN to insert BLANK_CYC dark cycles between sources.
module hex_display_scheduler
    import hex_sched_pkg::*;
#(
    parameter int DWELL     = 50_000_000,
    parameter int BLANK_CYC = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       step,
    input  logic       hold,
    input  logic       live,
    output logic [6:0] out1,
    output logic [6:0] out0,
    output logic [1:0] sel,
    output logic [3:0] sel_led
);

    localparam int CW = $clog2(DWELL);

    state_t          state_q, state_d;
    logic [1:0]      sel_q;
    logic [1:0]      sel_nx;
    logic [7:0]      snap_q;
    logic [CW-1:0]   cnt_q;
    logic            step_d;
    logic            step_rise;
    logic            dwell_done;
    logic            adv;
    logic [7:0]      src [NUM_SRC];
    logic [6:0]      seg_hi, seg_lo;

`ifdef HEX_SCHED_BLANK_EN
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    logic [BW-1:0]   bcnt_q;
    logic            blank_done;
    assign blank_done = (bcnt_q == BW'(BLANK_CYC - 1));
`endif

    always_comb begin
        src[0] = in0;
        src[1] = in1;
        src[2] = in2;
        src[3] = in3;
    end

    assign sel_nx     = sel_q + 2'd1;
    assign step_rise  = step & ~step_d;
    assign dwell_done = (cnt_q == CW'(DWELL - 1)) & ~hold;
    // A dwell expiry and a key edge in the same cycle still give a single advance.
    assign adv        = (state_q == SHOW) & (dwell_done | step_rise);

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= SHOW;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
`ifdef HEX_SCHED_BLANK_EN
        case (state_q)
            SHOW:    if (adv)        state_d = BLANK;
            BLANK:   if (blank_done) state_d = SHOW;
            default:                 state_d = SHOW;
        endcase
`else
        state_d = SHOW;
`endif
    end

    // Source select, snapshot and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q  <= 2'd0;
            snap_q <= 8'h00;
            cnt_q  <= '0;
            step_d <= 1'b0;
`ifdef HEX_SCHED_BLANK_EN
            bcnt_q <= '0;
`endif
        end else begin
            step_d <= step;
            if (state_q == SHOW) begin
                if (adv) begin
                    sel_q <= sel_nx;
                    cnt_q <= '0;
`ifdef HEX_SCHED_BLANK_EN
                    bcnt_q <= '0;
`else
                    snap_q <= src[sel_nx];
`endif
                end else begin
                    if (!hold) cnt_q  <= cnt_q + CW'(1);
                    if (live)  snap_q <= src[sel_q];
                end
            end
`ifdef HEX_SCHED_BLANK_EN
            else begin
                // Step edges here are dropped; step_d still tracks so nothing is deferred.
                bcnt_q <= bcnt_q + BW'(1);
                if (blank_done) begin
                    snap_q <= src[sel_q];
                    cnt_q  <= '0;
                end
            end
`endif
        end
    end

    hex_display_scheduler_seg7 u_seg_hi (.nib(snap_q[7:4]), .seg(seg_hi));
    hex_display_scheduler_seg7 u_seg_lo (.nib(snap_q[3:0]), .seg(seg_lo));

    // FSM: outputs
    always_comb begin
        out1    = seg_hi;
        out0    = seg_lo;
        sel     = sel_q;
        sel_led = sel_onehot(sel_q);
        if (state_q == BLANK) begin
            out1 = SEG_BLANK;
            out0 = SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler with DWELL=4, BLANK_CYC=3.
// The blanking scenario runs when HEX_SCHED_BLANK_EN is defined, the direct-switch ones otherwise.
module tb_hex_display_scheduler;

    logic       clock = 1'b0;
    logic       reset, step, hold, live;
    logic [7:0] in0, in1, in2, in3;
    logic [6:0] out1, out0;
    logic [1:0] sel;
    logic [3:0] sel_led;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           SA = 7'b0001000, SC = 7'b1000110, SOFF = 7'b1111111;

    hex_display_scheduler #(.DWELL(4), .BLANK_CYC(3)) dut (
        .clock(clock), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .step(step), .hold(hold), .live(live),
        .out1(out1), .out0(out0), .sel(sel), .sel_led(sel_led)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; step = 1'b0; hold = 1'b0; live = 1'b0;
        in0 = 8'h12; in1 = 8'h34; in2 = 8'h56; in3 = 8'h78;
        tick(2);
        reset = 1'b0;
        n_vec++;
        if (sel !== 2'd0 || sel_led !== 4'b0001 || out1 !== S0 || out0 !== S0) begin
            n_err++;
            $display("FAIL reset: sel=%0d led=%b out1=%b out0=%b, want 0 0001 %b %b",
                     sel, sel_led, out1, out0, S0, S0);
        end
        tick(3);
        n_vec++;
        if (sel !== 2'd0) begin
            n_err++;
            $display("FAIL dwell_not_yet: sel=%0d, want 0", sel);
        end
        tick(1);
        n_vec++;
        if (sel !== 2'd1 || sel_led !== 4'b0010) begin
            n_err++;
            $display("FAIL first_advance: sel=%0d led=%b, want 1 0010", sel, sel_led);
        end
    endtask

`ifndef HEX_SCHED_BLANK_EN
    task automatic test_first_digits;
        n_vec++;
        if (out1 !== S3 || out0 !== S4) begin
            n_err++;
            $display("FAIL first_digits: out1=%b out0=%b, want %b %b", out1, out0, S3, S4);
        end
    endtask

    task automatic test_rotation;
        logic [1:0] exp_sel [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] exp_led [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [6:0] exp_hi  [4] = '{S5, S7, S1, S3};
        logic [6:0] exp_lo  [4] = '{S6, S8, S2, S4};
        for (int k = 0; k < 4; k++) begin
            tick(4);
            n_vec++;
            if (sel !== exp_sel[k] || sel_led !== exp_led[k] ||
                out1 !== exp_hi[k] || out0 !== exp_lo[k]) begin
                n_err++;
                $display("FAIL rotation[%0d]: sel=%0d led=%b out1=%b out0=%b, want %0d %b %b %b",
                         k, sel, sel_led, out1, out0, exp_sel[k], exp_led[k], exp_hi[k], exp_lo[k]);
            end
        end
    endtask

    task automatic test_hold;
        hold = 1'b1;
        tick(20);
        n_vec++;
        if (sel !== 2'd1) begin
            n_err++;
            $display("FAIL hold_freeze: sel=%0d, want 1", sel);
        end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(1);
        n_vec++;
        if (sel !== 2'd2 || out1 !== S5 || out0 !== S6) begin
            n_err++;
            $display("FAIL hold_step: sel=%0d out1=%b out0=%b, want 2 %b %b", sel, out1, out0, S5, S6);
        end
        step = 1'b1;
        tick(10);
        n_vec++;
        if (sel !== 2'd3) begin
            n_err++;
            $display("FAIL held_key: sel=%0d, want 3", sel);
        end
        step = 1'b0;
        tick(1);
        hold = 1'b0;
    endtask

    task automatic test_back_to_back;
        // counter is 0 here; three cycles bring it to the expiry value
        tick(3);
        n_vec++;
        if (sel !== 2'd3) begin
            n_err++;
            $display("FAIL pre_collide: sel=%0d, want 3", sel);
        end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        n_vec++;
        if (sel !== 2'd0 || out1 !== S1 || out0 !== S2) begin
            n_err++;
            $display("FAIL collide: sel=%0d out1=%b out0=%b, want 0 %b %b", sel, out1, out0, S1, S2);
        end
        tick(3);
        n_vec++;
        if (sel !== 2'd0) begin
            n_err++;
            $display("FAIL collide_restart: sel=%0d, want 0", sel);
        end
        tick(1);
        n_vec++;
        if (sel !== 2'd1) begin
            n_err++;
            $display("FAIL collide_next: sel=%0d, want 1", sel);
        end
    endtask

    task automatic test_live;
        hold = 1'b1;
        step = 1'b1; tick(1); step = 1'b0; tick(1);
        n_vec++;
        if (sel !== 2'd2) begin
            n_err++;
            $display("FAIL live_setup: sel=%0d, want 2", sel);
        end
        live = 1'b1;
        in2  = 8'hA5;
        tick(1);
        n_vec++;
        if (out1 !== SA || out0 !== S5) begin
            n_err++;
            $display("FAIL live_update: out1=%b out0=%b, want %b %b", out1, out0, SA, S5);
        end
        live = 1'b0;
        in2  = 8'h3C;
        tick(3);
        n_vec++;
        if (out1 !== SA || out0 !== S5) begin
            n_err++;
            $display("FAIL live_off: out1=%b out0=%b, want %b %b", out1, out0, SA, S5);
        end
        for (int k = 0; k < 4; k++) begin
            step = 1'b1; tick(1); step = 1'b0; tick(1);
        end
        n_vec++;
        if (sel !== 2'd2 || out1 !== S3 || out0 !== SC) begin
            n_err++;
            $display("FAIL reentry: sel=%0d out1=%b out0=%b, want 2 %b %b", sel, out1, out0, S3, SC);
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_mid;
        tick(2);
        reset = 1'b1; tick(1); reset = 1'b0;
        n_vec++;
        if (sel !== 2'd0 || out1 !== S0 || out0 !== S0) begin
            n_err++;
            $display("FAIL reset_mid: sel=%0d out1=%b out0=%b, want 0 %b %b", sel, out1, out0, S0, S0);
        end
        tick(2);
        n_vec++;
        if (out1 !== S0 || out0 !== S0) begin
            n_err++;
            $display("FAIL post_reset_snap: out1=%b out0=%b, want %b %b", out1, out0, S0, S0);
        end
    endtask
`else
    task automatic test_blank;
        // after test_reset: just entered BLANK for source 1
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (out1 !== SOFF || out0 !== SOFF || sel !== 2'd1) begin
                n_err++;
                $display("FAIL blank[%0d]: sel=%0d out1=%b out0=%b, want 1 %b %b",
                         k, sel, out1, out0, SOFF, SOFF);
            end
            if (k == 1) step = 1'b1;
            tick(1);
        end
        n_vec++;
        if (sel !== 2'd1 || out1 !== S3 || out0 !== S4) begin
            n_err++;
            $display("FAIL blank_exit: sel=%0d out1=%b out0=%b, want 1 %b %b", sel, out1, out0, S3, S4);
        end
        tick(1);
        step = 1'b0;
        n_vec++;
        if (sel !== 2'd1 || out1 !== S3) begin
            n_err++;
            $display("FAIL blank_step_ignored: sel=%0d out1=%b, want 1 %b", sel, out1, S3);
        end
        tick(1);
        step = 1'b1; tick(1); step = 1'b0;
        n_vec++;
        if (sel !== 2'd2 || out1 !== SOFF) begin
            n_err++;
            $display("FAIL blank_again: sel=%0d out1=%b, want 2 %b", sel, out1, SOFF);
        end
        tick(1);
        reset = 1'b1; tick(1); reset = 1'b0;
        n_vec++;
        if (sel !== 2'd0 || out1 !== S0 || out0 !== S0 || sel_led !== 4'b0001) begin
            n_err++;
            $display("FAIL blank_reset: sel=%0d out1=%b out0=%b led=%b, want 0 %b %b 0001",
                     sel, out1, out0, sel_led, S0, S0);
        end
    endtask
`endif

    initial begin
        test_reset;
`ifndef HEX_SCHED_BLANK_EN
        test_first_digits;
        test_rotation;
        test_hold;
        test_back_to_back;
        test_live;
        test_reset_mid;
`else
        test_blank;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
